// File: rtl/irq_timer_pkg.sv
// Shared definitions for the interrupt timer peripheral: operating modes, countdown
// states, register byte offsets and status bit positions.
package irq_timer_pkg;

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeNtimes  = 2'd1,
        ModeForever = 2'd2
    } mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Register byte offsets
    localparam int unsigned SYSCNT_LO = 32'h00;
    localparam int unsigned SYSCNT_HI = 32'h04;
    localparam int unsigned DELAY_LO  = 32'h08;
    localparam int unsigned DELAY_HI  = 32'h0C;
    localparam int unsigned MODE      = 32'h10;
    localparam int unsigned REPEAT    = 32'h14;
    localparam int unsigned STATUS    = 32'h18;
    localparam int unsigned CTRL      = 32'h1C;

    // Status register bit positions
    localparam int unsigned STATUS_PENDING = 0;
    localparam int unsigned STATUS_OVERRUN = 1;

endpackage

// File: rtl/irq_timer_core.sv
// Countdown engine of the interrupt timer: holds mode, repeat count, countdown value and
// the sticky pending/overrun flags.
//   clk_i, rst_i        clock, asynchronous active-low reset
//   soft_rst_i          synchronous clear of all state
//   delay_i             reload value for the countdown
//   mode_we_i/_wdata_i  mode register write
//   rep_we_i/_wdata_i   repeat register write
//   clr_overrun_i       status read, clears overrun
//   irq_ret_i           interrupt return pulse, clears pending
//   mode_o, rep_o       register readback
//   pending_o, overrun_o, irq_o  status flags and interrupt request
module irq_timer_core
    import irq_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             soft_rst_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic             mode_we_i,
    input  logic [1:0]       mode_wdata_i,
    input  logic             rep_we_i,
    input  logic [31:0]      rep_wdata_i,
    input  logic             clr_overrun_i,
    input  logic             irq_ret_i,
    output mode_e            mode_o,
    output logic [31:0]      rep_o,
    output logic             pending_o,
    output logic             overrun_o,
    output logic             irq_o
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rep_q, rep_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        expire    = (state_q == StRun) && (cnt_q == CNT_W'(1));

        unique case (state_q)
            StIdle: ;
            StRun: begin
                if (expire) begin
                    cnt_d = delay_i;
                    if (mode_q == ModeNtimes) begin
                        rep_d = rep_q - 32'd1;
                        if (rep_q == 32'd1) begin
                            mode_d  = ModeOff;
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (rep_we_i) begin
            rep_d = rep_wdata_i;
        end

        if (mode_we_i) begin
            case (mode_wdata_i)
                ModeOff: begin
                    mode_d  = ModeOff;
                    state_d = StIdle;
                end
                ModeNtimes, ModeForever: begin
                    // A zero delay or an empty NTIMES budget never starts the countdown
                    if (delay_i == '0 || (mode_wdata_i == ModeNtimes && rep_q == '0)) begin
                        mode_d  = ModeOff;
                        state_d = StIdle;
                    end else begin
                        mode_d  = mode_e'(mode_wdata_i);
                        state_d = StRun;
                        cnt_d   = delay_i;
                    end
                end
                default: ;  // reserved encoding leaves the mode untouched
            endcase
        end

        // Clear first so a coincident overrun event still sets the flag
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end

        if (expire) begin
            pending_d = 1'b1;
            // A return in the same cycle consumes the old request, so nothing is lost
            if (pending_q && !irq_ret_i) begin
                overrun_d = 1'b1;
            end
        end else if (irq_ret_i) begin
            pending_d = 1'b0;
        end

        if (soft_rst_i) begin
            state_d   = StIdle;
            mode_d    = ModeOff;
            cnt_d     = '0;
            rep_d     = '0;
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            mode_q    <= ModeOff;
            cnt_q     <= '0;
            rep_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign mode_o    = mode_q;
    assign rep_o     = rep_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    assign irq_o     = pending_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt timer: free-running system counter, programmable delay and
// mode, sticky interrupt request to the core. Supports CNT_W up to 64.
//   clk_i, rst_i        clock, asynchronous active-low reset
//   req_i               bus request strobe, one cycle per access
//   write_enable_i      1 = write, 0 = read
//   addr_i              word-aligned byte offset
//   write_data_i        write data
//   read_data_o         registered read data, held until the next read
//   ready_o             access complete, req_i delayed one cycle
//   irq_req_o           interrupt request to the core
//   irq_ret_i           interrupt return pulse from the core
module irq_timer_ctrl
    import irq_timer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_enable_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       write_data_i,
    output logic [31:0]       read_data_o,
    output logic              ready_o,
    output logic              irq_req_o,
    input  logic              irq_ret_i
);

    logic [CNT_W-1:0] sys_cnt_q;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [31:0]      read_data_q;
    logic             ready_q;
    logic [63:0]      sys_cnt_w, delay_w;
    logic [31:0]      rdata;
    logic             wr, rd, soft_rst, mode_we, rep_we, clr_overrun;
    mode_e            mode;
    logic [31:0]      rep;
    logic             pending, overrun;

    // Zero-extended 64-bit views so the halves can be addressed uniformly
    assign sys_cnt_w = 64'(sys_cnt_q);
    assign delay_w   = 64'(delay_q);

    always_comb begin
        wr          = req_i & write_enable_i;
        rd          = req_i & ~write_enable_i;
        delay_d     = delay_q;
        soft_rst    = 1'b0;
        mode_we     = 1'b0;
        rep_we      = 1'b0;
        clr_overrun = 1'b0;
        rdata       = '0;
        case (addr_i)
            ADDR_W'(SYSCNT_LO): rdata = sys_cnt_w[31:0];
            ADDR_W'(SYSCNT_HI): rdata = sys_cnt_w[63:32];
            ADDR_W'(DELAY_LO): begin
                rdata = delay_w[31:0];
                if (wr) delay_d = CNT_W'({delay_w[63:32], write_data_i});
            end
            ADDR_W'(DELAY_HI): begin
                rdata = delay_w[63:32];
                if (wr) delay_d = CNT_W'({write_data_i, delay_w[31:0]});
            end
            ADDR_W'(MODE): begin
                rdata   = 32'(mode);
                mode_we = wr;
            end
            ADDR_W'(REPEAT): begin
                rdata  = rep;
                rep_we = wr;
            end
            ADDR_W'(STATUS): begin
                rdata[STATUS_PENDING] = pending;
                rdata[STATUS_OVERRUN] = overrun;
                clr_overrun           = rd;
            end
            ADDR_W'(CTRL): soft_rst = wr & write_data_i[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sys_cnt_q   <= '0;
            delay_q     <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            sys_cnt_q <= sys_cnt_q + CNT_W'(1);
            // ready still acknowledges the soft-reset write itself
            ready_q   <= req_i;
            if (soft_rst) begin
                delay_q     <= '0;
                read_data_q <= '0;
            end else begin
                delay_q <= delay_d;
                if (rd) read_data_q <= rdata;
            end
        end
    end

    irq_timer_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .soft_rst_i   (soft_rst),
        .delay_i      (delay_q),
        .mode_we_i    (mode_we),
        .mode_wdata_i (write_data_i[1:0]),
        .rep_we_i     (rep_we),
        .rep_wdata_i  (write_data_i),
        .clr_overrun_i(clr_overrun),
        .irq_ret_i    (irq_ret_i),
        .mode_o       (mode),
        .rep_o        (rep),
        .pending_o    (pending),
        .overrun_o    (overrun),
        .irq_o        (irq_req_o)
    );

    assign read_data_o = read_data_q;
    assign ready_o     = ready_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: a register-access vector table followed by
// hand-written multi-cycle sequences for expiry timing, coalescing and resets.
module tb_irq_timer_ctrl;
    import irq_timer_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              ready;
    logic              irq;
    logic              irq_ret = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_timer_ctrl #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .write_enable_i(we),
        .addr_i        (addr),
        .write_data_i  (wdata),
        .read_data_o   (rdata),
        .ready_o       (ready),
        .irq_req_o     (irq),
        .irq_ret_i     (irq_ret)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with req dropped.
    task automatic bus(input logic a_we, input logic [7:0] a_addr, input logic [31:0] a_wdata,
                       output logic [31:0] a_rdata);
        req   = 1'b1;
        we    = a_we;
        addr  = a_addr;
        wdata = a_wdata;
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        a_rdata = rdata;
        check("ready one cycle after req", {63'd0, ready}, 64'd1);
    endtask

    task automatic wr(input logic [7:0] a_addr, input logic [31:0] a_wdata);
        logic [31:0] dummy;
        bus(1'b1, a_addr, a_wdata, dummy);
    endtask

    task automatic rd(input logic [7:0] a_addr, output logic [31:0] a_rdata);
        bus(1'b0, a_addr, 32'd0, a_rdata);
    endtask

    initial begin
        logic [31:0] a, b, d;
        int          rise_at[4];
        int          n_rise, ret_at, cnt;
        logic        prev;
        logic [7:0]  clr_list[5];

        // Register access table: {we, addr, wdata, expected read}
        vecs.push_back('{1'b1, 8'h08, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 8'h0C, 32'h00000001, 32'h0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0, 32'h00000001});
        vecs.push_back('{1'b0, 8'h08, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 8'h14, 32'h7, 32'h0});
        vecs.push_back('{1'b0, 8'h14, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h10, 32'h3, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h18, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{1'b0, 8'h18, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h1C, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h24, 32'h12345678, 32'h0});
        vecs.push_back('{1'b0, 8'h24, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h20, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h0C, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h10, 32'h2, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h10, 32'h1, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h14, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 8'h04, 32'h0, 32'h0});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset irq", {63'd0, irq}, 64'd0);
        check("reset read_data", {32'd0, rdata}, 64'd0);
        rst = 1'b1;

        // sys_cnt advances by the access spacing
        rd(8'h00, a);
        @(negedge clk);
        check("ready low when idle", {63'd0, ready}, 64'd0);
        repeat (3) @(negedge clk);
        rd(8'h00, b);
        check("sys_cnt delta 5", {32'd0, b - a}, 64'd5);
        check("irq idle", {63'd0, irq}, 64'd0);

        // Register table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr, d);
                check($sformatf("vec%0d addr 0x%0h", i, vecs[i].addr), {32'd0, d},
                      {32'd0, vecs[i].exp});
            end
        end

        // Zero delay never fires
        wr(8'h1C, 32'h1);
        wr(8'h10, 32'h2);
        rd(8'h10, d);
        check("zero delay mode", {32'd0, d}, 64'd0);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (irq) cnt++;
        end
        check("zero delay irq count", 64'(cnt), 64'd0);
        rd(8'h00, a);
        wr(8'h00, 32'h0);
        rd(8'h00, b);
        check("sys_cnt write ignored", {32'd0, b - a}, 64'd2);
        wr(8'h04, 32'hFFFFFFFF);
        rd(8'h04, d);
        check("sys_cnt hi write ignored", {32'd0, d}, 64'd0);
        rd(8'h20, d);
        check("unmapped 0x20", {32'd0, d}, 64'd0);

        // NTIMES x3, returning two cycles after each rise
        wr(8'h08, 32'd10);
        wr(8'h0C, 32'd0);
        wr(8'h14, 32'd3);
        wr(8'h10, 32'd1);
        n_rise = 0;
        ret_at = -1;
        prev   = irq;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            irq_ret = (k == ret_at);
            if (irq && !prev) begin
                if (n_rise < 4) rise_at[n_rise] = k;
                n_rise++;
                ret_at = k + 2;
            end
            prev = irq;
        end
        irq_ret = 1'b0;
        check("ntimes rise count", 64'(n_rise), 64'd3);
        check("ntimes first rise", 64'(rise_at[0]), 64'd10);
        check("ntimes spacing 1", 64'(rise_at[1] - rise_at[0]), 64'd10);
        check("ntimes spacing 2", 64'(rise_at[2] - rise_at[1]), 64'd10);
        rd(8'h10, d);
        check("ntimes mode off", {32'd0, d}, 64'd0);
        rd(8'h14, d);
        check("ntimes repeat drained", {32'd0, d}, 64'd0);
        check("ntimes irq low", {63'd0, irq}, 64'd0);

        // FOREVER without returns: coalescing and overrun
        wr(8'h08, 32'd4);
        wr(8'h10, 32'd2);
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 5 && !irq) cnt++;
        end
        check("forever irq held", 64'(cnt), 64'd0);
        rd(8'h18, d);
        check("status overrun", {32'd0, d}, 64'd3);
        rd(8'h18, d);
        check("status overrun cleared", {32'd0, d}, 64'd1);
        wr(8'h10, 32'd3);
        rd(8'h10, d);
        check("mode 3 keeps forever", {32'd0, d}, 64'd2);
        wr(8'h10, 32'd0);
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
        check("return clears irq", {63'd0, irq}, 64'd0);

        // Return coinciding with an expiry
        wr(8'h1C, 32'h1);
        wr(8'h08, 32'd6);
        wr(8'h10, 32'd2);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            irq_ret = (k == 11);
            if (k == 5) check("irq before first expiry", {63'd0, irq}, 64'd0);
            if (k == 6) check("irq at first expiry", {63'd0, irq}, 64'd1);
            if (k == 12) check("event beats return", {63'd0, irq}, 64'd1);
        end
        rd(8'h18, d);
        check("no overrun on coincident return", {32'd0, d}, 64'd1);

        // Soft reset mid-run
        wr(8'h08, 32'd20);
        wr(8'h14, 32'd5);
        wr(8'h10, 32'd2);
        repeat (25) @(negedge clk);
        check("irq before soft reset", {63'd0, irq}, 64'd1);
        rd(8'h00, a);
        wr(8'h1C, 32'h1);
        check("irq after soft reset", {63'd0, irq}, 64'd0);
        clr_list = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        for (int i = 0; i < 5; i++) begin
            rd(clr_list[i], d);
            check($sformatf("soft reset clears 0x%0h", clr_list[i]), {32'd0, d}, 64'd0);
        end
        rd(8'h00, b);
        check("sys_cnt survives soft reset", {32'd0, b - a}, 64'd7);

        // Hard reset mid-count
        wr(8'h08, 32'd3);
        wr(8'h10, 32'd2);
        repeat (8) @(negedge clk);
        check("irq before hard reset", {63'd0, irq}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async irq drop", {63'd0, irq}, 64'd0);
        check("async ready drop", {63'd0, ready}, 64'd0);
        check("async read_data clear", {32'd0, rdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd(8'h00, d);
        check("sys_cnt lo after reset", {32'd0, d}, 64'd0);
        rd(8'h04, d);
        check("sys_cnt hi after reset", {32'd0, d}, 64'd0);
        rd(8'h10, d);
        check("mode after reset", {32'd0, d}, 64'd0);
        rd(8'h08, d);
        check("delay after reset", {32'd0, d}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
